// File: rtl/mw_loadext_pkg.sv
// Shared definitions for the M/W load-extension register slice:
// load-type codes and the packed layout of the W-stage register.
package mw_loadext_pkg;

   // Load-type codes carried on ldctr; any other code behaves as a full word load.
   localparam logic [2:0] ld_lw  = 3'd0;
   localparam logic [2:0] ld_lbu = 3'd1;
   localparam logic [2:0] ld_lb  = 3'd2;
   localparam logic [2:0] ld_lhu = 3'd3;
   localparam logic [2:0] ld_lh  = 3'd4;

   // Everything W needs to finish an instruction. An all-zero value is a bubble.
   typedef struct packed {
      logic [31:0] pc8;
      logic [4:0]  a3;
      logic        regwrite;
      logic        memtoreg;
      logic [2:0]  ldctr;
      logic [1:0]  off;
      logic [31:0] rdata;
      logic [31:0] result;
      logic        valid;
   } mw_fields_t;

endpackage

// File: rtl/mw_loadext_ldext.sv
// Load-data extension: picks the addressed byte or halfword out of the
// raw memory word and zero- or sign-extends it to 32 bits.
import mw_loadext_pkg::*;

module ldext (
   input  logic [31:0] rdata,
   input  logic [1:0]  off,
   input  logic [2:0]  ldctr,
   output logic [31:0] ext32
);

   logic [7:0]  byte_lane [4];
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Split the word into its four byte lanes so the offset can index them directly.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign byte_lane[gi] = rdata[8*gi +: 8];
      end
   endgenerate

   assign byte_sel = byte_lane[off];
   // off[0] is don't-care for halfwords; misaligned halves never get this far.
   assign half_sel = off[1] ? rdata[31:16] : rdata[15:0];

   // Extend the selected lane according to the load type.
   always_comb begin
      ext32 = rdata;
      case (ldctr)
         ld_lbu:  ext32 = {24'h0, byte_sel};
         ld_lb:   ext32 = {{24{byte_sel[7]}}, byte_sel};
         ld_lhu:  ext32 = {16'h0, half_sel};
         ld_lh:   ext32 = {{16{half_sel[15]}}, half_sel};
         default: ext32 = rdata;
      endcase
   end

endmodule

// File: rtl/mw_loadext.sv
// M/W pipeline register. Captures the raw load word, byte offset and
// write-back control from M, then produces the final GPR write data in W.
import mw_loadext_pkg::*;

module mw_loadext (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        flush,
   input  logic [31:0] pc8_m,
   input  logic [31:0] memaddr_m,
   input  logic [31:0] dm_m,
   input  logic [2:0]  ldctr_m,
   input  logic        memtoreg_m,
   input  logic [31:0] result_m,
   input  logic        regwrite_m,
   input  logic [4:0]  a3_m,
   output logic [31:0] pc8_w,
   output logic [4:0]  a3_w,
   output logic        regwrite_w,
   output logic [31:0] wd_w,
   output logic        valid_w
);

   mw_fields_t w_reg;
   mw_fields_t w_next;
   logic [31:0] ext32;

   // Gather the M-stage inputs into the W register layout.
   always_comb begin
      w_next          = '0;
      w_next.pc8      = pc8_m;
      w_next.a3       = a3_m;
      w_next.regwrite = regwrite_m;
      w_next.memtoreg = memtoreg_m;
      w_next.ldctr    = ldctr_m;
      w_next.off      = memaddr_m[1:0];
      w_next.rdata    = dm_m;
      w_next.result   = result_m;
      w_next.valid    = 1'b1;
   end

   // W register: reset and flush both insert a bubble and override stall.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         w_reg <= '0;
      end else if (!stall) begin
         w_reg <= w_next;
      end
   end

   ldext u_ldext (
      .rdata (w_reg.rdata),
      .off   (w_reg.off),
      .ldctr (w_reg.ldctr),
      .ext32 (ext32)
   );

   // Outputs depend only on registered fields, so there is no M-to-W combinational path.
   // A bubble has memtoreg=0 and result=0, so wd_w is 0 for it as well.
   assign pc8_w      = w_reg.pc8;
   assign a3_w       = w_reg.a3;
   assign valid_w    = w_reg.valid;
   assign regwrite_w = w_reg.regwrite & (w_reg.a3 != 5'd0) & w_reg.valid;
   assign wd_w       = w_reg.memtoreg ? ext32 : w_reg.result;

endmodule

// File: tb/tb_mw_loadext.sv
// Self-checking bench for mw_loadext: directed cases with fixed expected
// values, then randomized traffic against a behavioural W-stage model.
module tb_mw_loadext;

   logic        clk = 1'b0;
   logic        rst, stall, flush;
   logic [31:0] pc8_m, memaddr_m, dm_m, result_m;
   logic [2:0]  ldctr_m;
   logic        memtoreg_m, regwrite_m;
   logic [4:0]  a3_m;
   logic [31:0] pc8_w, wd_w;
   logic [4:0]  a3_w;
   logic        regwrite_w, valid_w;

   int tests_run = 0;
   int tests_failed = 0;

   // Expected W-stage state as the model sees it.
   logic [31:0] m_pc8, m_wd;
   logic [4:0]  m_a3;
   logic        m_rw, m_valid;

   mw_loadext dut (
      .clk        (clk),
      .rst        (rst),
      .stall      (stall),
      .flush      (flush),
      .pc8_m      (pc8_m),
      .memaddr_m  (memaddr_m),
      .dm_m       (dm_m),
      .ldctr_m    (ldctr_m),
      .memtoreg_m (memtoreg_m),
      .result_m   (result_m),
      .regwrite_m (regwrite_m),
      .a3_m       (a3_m),
      .pc8_w      (pc8_w),
      .a3_w       (a3_w),
      .regwrite_w (regwrite_w),
      .wd_w       (wd_w),
      .valid_w    (valid_w)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference load extension using shifts, masks and two's-complement arithmetic.
   function automatic logic [31:0] ref_load(input logic [31:0] d, input logic [1:0] off,
                                            input logic [2:0] ld);
      logic [31:0] v;
      case (ld)
         3'd1, 3'd2: begin
            v = (d >> (8 * int'(off))) & 32'hFF;
            if (ld == 3'd2 && v >= 32'd128) v = v - 32'd256;
         end
         3'd3, 3'd4: begin
            v = (off >= 2'd2) ? (d >> 16) : (d & 32'hFFFF);
            if (ld == 3'd4 && v >= 32'd32768) v = v - 32'd65536;
         end
         default: v = d;
      endcase
      return v;
   endfunction

   // Advance one clock: update the model from the inputs present at the edge,
   // then compare every output shortly after the edge.
   task automatic tick();
      if (rst || flush) begin
         m_pc8 = '0; m_a3 = '0; m_rw = 1'b0; m_wd = '0; m_valid = 1'b0;
      end else if (!stall) begin
         m_pc8   = pc8_m;
         m_a3    = a3_m;
         m_rw    = regwrite_m && (a3_m != 5'd0);
         m_wd    = memtoreg_m ? ref_load(dm_m, memaddr_m[1:0], ldctr_m) : result_m;
         m_valid = 1'b1;
      end
      @(posedge clk);
      #1;
      chk("pc8_w", pc8_w, m_pc8);
      chk("a3_w", 32'(a3_w), 32'(m_a3));
      chk("regwrite_w", 32'(regwrite_w), 32'(m_rw));
      chk("wd_w", wd_w, m_wd);
      chk("valid_w", 32'(valid_w), 32'(m_valid));
   endtask

   task automatic drive(input logic [31:0] pc8, input logic [1:0] off, input logic [31:0] dm,
                        input logic [2:0] ld, input logic m2r, input logic [31:0] res,
                        input logic rw, input logic [4:0] a3);
      pc8_m = pc8; memaddr_m = {$urandom} & 32'hFFFF_FFFC | {30'h0, off}; dm_m = dm;
      ldctr_m = ld; memtoreg_m = m2r; result_m = res; regwrite_m = rw; a3_m = a3;
   endtask

   task automatic randomize_inputs();
      pc8_m = $urandom; memaddr_m = $urandom; dm_m = $urandom; result_m = $urandom;
      ldctr_m = 3'($urandom_range(0, 7)); memtoreg_m = 1'($urandom);
      regwrite_m = 1'($urandom); a3_m = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; flush = 1'b0;
      m_pc8 = '0; m_a3 = '0; m_rw = 1'b0; m_wd = '0; m_valid = 1'b0;
      randomize_inputs();

      // Reset with arbitrary inputs and a stall that must be ignored.
      stall = 1'b1;
      tick();
      randomize_inputs();
      tick();
      chk("rst_valid", 32'(valid_w), 32'd0);
      chk("rst_wd", wd_w, 32'd0);
      $display("[TB] reset: pc8_w=%h wd_w=%h valid_w=%b", pc8_w, wd_w, valid_w);
      rst = 1'b0; stall = 1'b0;

      // Byte loads.
      drive(32'h100, 2'b11, 32'h80FF7F01, 3'd2, 1'b1, 32'h0, 1'b1, 5'd8);
      tick();
      chk("lb_sign", wd_w, 32'hFFFFFF80);
      chk("lb_rw", 32'(regwrite_w), 32'd1);
      chk("lb_a3", 32'(a3_w), 32'd8);
      $display("[TB] lb off=3: wd_w=%h", wd_w);
      ldctr_m = 3'd1;
      tick();
      chk("lbu_zero", wd_w, 32'h00000080);
      $display("[TB] lbu off=3: wd_w=%h", wd_w);
      drive(32'h104, 2'b00, 32'h80FF7F01, 3'd2, 1'b1, 32'h0, 1'b1, 5'd8);
      tick();
      chk("lb_off0", wd_w, 32'h00000001);
      $display("[TB] lb off=0: wd_w=%h", wd_w);

      // Halfword loads.
      drive(32'h108, 2'b10, 32'h8001FFFE, 3'd4, 1'b1, 32'h0, 1'b1, 5'd9);
      tick();
      chk("lh_hi", wd_w, 32'hFFFF8001);
      $display("[TB] lh off=2: wd_w=%h", wd_w);
      drive(32'h10C, 2'b00, 32'h8001FFFE, 3'd3, 1'b1, 32'h0, 1'b1, 5'd9);
      tick();
      chk("lhu_lo", wd_w, 32'h0000FFFE);
      $display("[TB] lhu off=0: wd_w=%h", wd_w);

      // Load word, then hold through three stalled cycles with changing inputs.
      drive(32'h110, 2'b00, 32'hDEADBEEF, 3'd0, 1'b1, 32'h0, 1'b1, 5'd3);
      tick();
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         randomize_inputs();
         tick();
         chk("stall_wd", wd_w, 32'hDEADBEEF);
         chk("stall_a3", 32'(a3_w), 32'd3);
         $display("[TB] stall %0d: wd_w=%h a3_w=%0d", i, wd_w, a3_w);
      end
      stall = 1'b0;

      // Writes to $0 are suppressed.
      drive(32'h114, 2'b00, 32'h1, 3'd0, 1'b0, 32'h55, 1'b1, 5'd0);
      tick();
      chk("a3_zero_rw", 32'(regwrite_w), 32'd0);
      $display("[TB] a3=0: regwrite_w=%b", regwrite_w);

      // Flush wins over stall while W holds a valid instruction.
      drive(32'h118, 2'b00, 32'h2, 3'd0, 1'b1, 32'h0, 1'b1, 5'd4);
      tick();
      stall = 1'b1; flush = 1'b1;
      tick();
      chk("flush_valid", 32'(valid_w), 32'd0);
      chk("flush_rw", 32'(regwrite_w), 32'd0);
      chk("flush_pc8", pc8_w, 32'd0);
      $display("[TB] flush+stall: valid_w=%b pc8_w=%h", valid_w, pc8_w);
      stall = 1'b0; flush = 1'b0;

      // Non-memory result path.
      drive(32'h11C, 2'b01, 32'hFFFFFFFF, 3'd2, 1'b0, 32'h12345678, 1'b1, 5'd5);
      tick();
      chk("alu_path", wd_w, 32'h12345678);
      $display("[TB] alu path: wd_w=%h", wd_w);

      // Randomized traffic with occasional reset, flush and stall.
      for (int i = 0; i < 400; i++) begin
         randomize_inputs();
         rst   = ($urandom_range(0, 49) == 0);
         flush = ($urandom_range(0, 9) == 0);
         stall = ($urandom_range(0, 3) == 0);
         tick();
         $display("[TB] rnd %0d: rst=%b fl=%b st=%b wd_w=%h exp=%h", i, rst, flush, stall, wd_w, m_wd);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
